id_ex_reg: RTL and testbench

- Pipeline register between the ID stage and EX_stage of the ARM core.
- Captures decoded control, operand values and immediates each cycle and presents them registered to EX_stage.
- Supports hazard freeze (stall) and branch flush (bubble insertion).
- Keeps saturating freeze/flush event counters for debug.

---
 rtl/id_ex_reg.sv | 103 ++++++++++
 tb/tb_id_ex_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with freeze, flush and saturating debug counters
module id_ex_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [31:0]      PC_in,
   input  logic             WB_EN_in,
   input  logic             MEM_R_EN_in,
   input  logic             MEM_W_EN_in,
   input  logic             B_in,
   input  logic             S_in,
   input  logic             I_in,
   input  logic [3:0]       EXE_CMD_in,
   input  logic [31:0]      Val_RN_in,
   input  logic [31:0]      Val_RM_in,
   input  logic [11:0]      imm_in,
   input  logic [11:0]      shift_operand_in,
   input  logic [23:0]      signed_immed_24_in,
   input  logic [3:0]       Dest_in,
   input  logic [3:0]       src1_in,
   input  logic [3:0]       src2_in,
   input  logic [3:0]       status_in,
   output logic             valid,
   output logic [31:0]      PC,
   output logic             WB_EN,
   output logic             MEM_R_EN,
   output logic             MEM_W_EN,
   output logic             B,
   output logic             S,
   output logic             I,
   output logic [3:0]       EXE_CMD,
   output logic [31:0]      Val_RN,
   output logic [31:0]      Val_RM,
   output logic [11:0]      imm,
   output logic [11:0]      shift_operand,
   output logic [23:0]      signed_immed_24,
   output logic [3:0]       Dest,
   output logic [3:0]       src1,
   output logic [3:0]       src2,
   output logic [3:0]       status,
   output logic [CNT_W-1:0] freeze_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   logic load;
   logic freeze_hit;
   assign load       = !flush && !freeze;
   assign freeze_hit = !flush && freeze;
   // flush clears every field so a bubble is fully deterministic
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         valid           <= 1'b0;
         PC              <= '0;
         WB_EN           <= 1'b0;
         MEM_R_EN        <= 1'b0;
         MEM_W_EN        <= 1'b0;
         B               <= 1'b0;
         S               <= 1'b0;
         I               <= 1'b0;
         EXE_CMD         <= '0;
         Val_RN          <= '0;
         Val_RM          <= '0;
         imm             <= '0;
         shift_operand   <= '0;
         signed_immed_24 <= '0;
         Dest            <= '0;
         src1            <= '0;
         src2            <= '0;
         status          <= '0;
      end else if (load) begin
         valid           <= valid_in;
         PC              <= PC_in;
         WB_EN           <= WB_EN_in & valid_in;
         MEM_R_EN        <= MEM_R_EN_in & valid_in;
         MEM_W_EN        <= MEM_W_EN_in & valid_in;
         B               <= B_in & valid_in;
         S               <= S_in & valid_in;
         I               <= I_in;
         EXE_CMD         <= EXE_CMD_in;
         Val_RN          <= Val_RN_in;
         Val_RM          <= Val_RM_in;
         imm             <= imm_in;
         shift_operand   <= shift_operand_in;
         signed_immed_24 <= signed_immed_24_in;
         Dest            <= Dest_in;
         src1            <= src1_in;
         src2            <= src2_in;
         status          <= status_in;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         freeze_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (freeze_hit && !(&freeze_cnt)) freeze_cnt <= freeze_cnt + 1'b1;
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized scoreboard bench for id_ex_reg against an abstract pipeline model
module tb_id_ex_reg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        wb, mr, mw, b, s, i;
      logic [3:0]  cmd;
      logic [31:0] rn, rm;
      logic [11:0] imm, sh;
      logic [23:0] off;
      logic [3:0]  dst, s1, s2, st;
   } pl_t;
   typedef struct packed {
      pl_t         p;
      logic [15:0] fc, lc;
      logic [1:0]  sfc, slc;
   } exp_t;

   logic clk = 1'b0;
   logic rst, flush, freeze;
   pl_t  din, dout, sout;
   logic [15:0] fc, lc;
   logic [1:0]  sfc, slc;

   logic        o_valid, o_wb, o_mr, o_mw, o_b, o_s, o_i;
   logic [31:0] o_pc, o_rn, o_rm;
   logic [3:0]  o_cmd, o_dst, o_s1, o_s2, o_st;
   logic [11:0] o_imm, o_sh;
   logic [23:0] o_off;
   logic        q_valid, q_wb, q_mr, q_mw, q_b, q_s, q_i;
   logic [31:0] q_pc, q_rn, q_rm;
   logic [3:0]  q_cmd, q_dst, q_s1, q_s2, q_st;
   logic [11:0] q_imm, q_sh;
   logic [23:0] q_off;

   assign dout = {o_valid, o_pc, o_wb, o_mr, o_mw, o_b, o_s, o_i, o_cmd, o_rn, o_rm,
                  o_imm, o_sh, o_off, o_dst, o_s1, o_s2, o_st};
   assign sout = {q_valid, q_pc, q_wb, q_mr, q_mw, q_b, q_s, q_i, q_cmd, q_rn, q_rm,
                  q_imm, q_sh, q_off, q_dst, q_s1, q_s2, q_st};

   always #5 clk = ~clk;

   id_ex_reg #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(din.valid),
      .PC_in(din.pc), .WB_EN_in(din.wb), .MEM_R_EN_in(din.mr), .MEM_W_EN_in(din.mw),
      .B_in(din.b), .S_in(din.s), .I_in(din.i), .EXE_CMD_in(din.cmd),
      .Val_RN_in(din.rn), .Val_RM_in(din.rm), .imm_in(din.imm), .shift_operand_in(din.sh),
      .signed_immed_24_in(din.off), .Dest_in(din.dst), .src1_in(din.s1), .src2_in(din.s2),
      .status_in(din.st),
      .valid(o_valid), .PC(o_pc), .WB_EN(o_wb), .MEM_R_EN(o_mr), .MEM_W_EN(o_mw),
      .B(o_b), .S(o_s), .I(o_i), .EXE_CMD(o_cmd), .Val_RN(o_rn), .Val_RM(o_rm),
      .imm(o_imm), .shift_operand(o_sh), .signed_immed_24(o_off), .Dest(o_dst),
      .src1(o_s1), .src2(o_s2), .status(o_st), .freeze_cnt(fc), .flush_cnt(lc)
   );

   id_ex_reg #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(din.valid),
      .PC_in(din.pc), .WB_EN_in(din.wb), .MEM_R_EN_in(din.mr), .MEM_W_EN_in(din.mw),
      .B_in(din.b), .S_in(din.s), .I_in(din.i), .EXE_CMD_in(din.cmd),
      .Val_RN_in(din.rn), .Val_RM_in(din.rm), .imm_in(din.imm), .shift_operand_in(din.sh),
      .signed_immed_24_in(din.off), .Dest_in(din.dst), .src1_in(din.s1), .src2_in(din.s2),
      .status_in(din.st),
      .valid(q_valid), .PC(q_pc), .WB_EN(q_wb), .MEM_R_EN(q_mr), .MEM_W_EN(q_mw),
      .B(q_b), .S(q_s), .I(q_i), .EXE_CMD(q_cmd), .Val_RN(q_rn), .Val_RM(q_rm),
      .imm(q_imm), .shift_operand(q_sh), .signed_immed_24(q_off), .Dest(q_dst),
      .src1(q_s1), .src2(q_s2), .status(q_st), .freeze_cnt(sfc), .flush_cnt(slc)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];
   pl_t  m;
   int   nfz, nfl;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int sat(input int n, input int mx);
      return n > mx ? mx : n;
   endfunction

   function automatic pl_t rnd_in();
      pl_t r;
      r.valid = $urandom_range(0, 3) != 0;
      r.pc = $urandom; r.wb = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
      r.b = 1'($urandom); r.s = 1'($urandom); r.i = 1'($urandom); r.cmd = 4'($urandom);
      r.rn = $urandom; r.rm = $urandom; r.imm = 12'($urandom); r.sh = 12'($urandom);
      r.off = 24'($urandom); r.dst = 4'($urandom); r.s1 = 4'($urandom);
      r.s2 = 4'($urandom); r.st = 4'($urandom);
      return r;
   endfunction

   // Model: flush empties the stage, freeze keeps it, otherwise the ID instruction moves in
   task automatic step(input pl_t in, input bit fl, input bit fz);
      exp_t e;
      @(negedge clk);
      rst = 1'b1; din = in; flush = fl; freeze = fz;
      if (fl) begin
         m = '0;
         nfl++;
      end else if (fz) begin
         nfz++;
      end else begin
         m = in;
         if (!in.valid) {m.wb, m.mr, m.mw, m.b, m.s} = 5'b0;
      end
      e.p = m;
      e.fc = 16'(sat(nfz, 65535));
      e.lc = 16'(sat(nfl, 65535));
      e.sfc = 2'(sat(nfz, 3));
      e.slc = 2'(sat(nfl, 3));
      sb.push_back(e);
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
         sb.delete();
      end
      #2;
   endtask

   task automatic check_zero(input string name);
      chk({name, "_pipe"}, 256'(dout), 256'(0));
      chk({name, "_fcnt"}, 256'(fc), 256'(0));
      chk({name, "_lcnt"}, 256'(lc), 256'(0));
      chk({name, "_sat_cnt"}, 256'({sfc, slc}), 256'(0));
   endtask

   task automatic do_reset(input string name);
      drain();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_zero(name);
      @(posedge clk);
      #1 check_zero({name, "_held"});
      m = '0; nfz = 0; nfl = 0;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("pipe", 256'(dout), 256'(e.p));
         chk("pipe_small", 256'(sout), 256'(e.p));
         chk("freeze_cnt", 256'(fc), 256'(e.fc));
         chk("flush_cnt", 256'(lc), 256'(e.lc));
         chk("sat_freeze_cnt", 256'(sfc), 256'(e.sfc));
         chk("sat_flush_cnt", 256'(slc), 256'(e.slc));
      end
   end

   initial begin
      pl_t t;
      rst = 1'b0; flush = 1'b0; freeze = 1'b0;
      din = rnd_in();
      din.valid = 1'b1;
      m = '0; nfz = 0; nfl = 0;
      #3 check_zero("reset_init");
      t = rnd_in(); t.pc = 32'h8; t.cmd = 4'b0010;
      step(t, 0, 0);
      t = rnd_in(); t.rn = 32'hDEADBEEF;
      step(t, 0, 0);
      t.rn = 32'h12345678;
      repeat (3) step(t, 0, 1);
      step(t, 0, 0);
      t = rnd_in(); t.valid = 1; t.wb = 1; t.mw = 1;
      step(t, 1, 0);
      t = rnd_in(); t.valid = 1; t.b = 1;
      step(t, 1, 1);
      t = rnd_in(); t.valid = 0; t.mr = 1; t.s = 1;
      step(t, 0, 0);
      do_reset("reset_mid");
      repeat (5) step(rnd_in(), 0, 1);
      step(rnd_in(), 0, 0);
      for (int n = 0; n < 400; n++)
         step(rnd_in(), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      repeat (4) step(rnd_in(), 0, 1);
      do_reset("reset_after_freeze");
      step(rnd_in(), 1, 1);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
